demux1to2_stream_wn: RTL and testbench

DEMUX1TO2_STREAM_WN -- requirements
Module: demux1to2_stream_wN

---
 rtl/demux1to2_stream_wn.sv | 142 ++++++++++++++
 tb/tb_demux1to2_stream_wn.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_stream_wn.sv
// 1-to-2 stream demultiplexer: each channel has a 2-entry FIFO and a wrapping transfer counter.
// Upstream readiness looks only at the registered full flag of the selected channel.

module demux1to2_chan #(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [N-1:0]  din,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [N-1:0]  o_data,
  output logic          o_full,
  output logic [CW-1:0] o_cnt
);
  // state    | meaning
  // ST_EMPTY | no word buffered, o_valid low
  // ST_ONE   | head holds the only word
  // ST_FULL  | head holds the oldest word, tail the newer one
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  head_q, head_d;
  logic [N-1:0]  tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd;

  assign rd = (state_q != ST_EMPTY) && o_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data registers carry no reset; they are only visible while o_valid is high.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (rd) cnt_d = cnt_q + CW'(1);
    case (state_q)
      ST_EMPTY: begin
        if (wr) begin
          head_d  = din;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (wr && rd) begin
          head_d = din;
        end else if (wr) begin
          tail_d  = din;
          state_d = ST_FULL;
        end else if (rd) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (rd) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign o_valid = (state_q != ST_EMPTY);
  assign o_data  = head_q;
  assign o_full  = (state_q == ST_FULL);
  assign o_cnt   = cnt_q;
endmodule

module demux1to2_stream_wn #(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [N-1:0]  i_data,
  input  logic          s,
  output logic          i_ready,
  output logic          a_valid,
  output logic [N-1:0]  a_data,
  input  logic          a_ready,
  output logic          b_valid,
  output logic [N-1:0]  b_data,
  input  logic          b_ready,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);
  logic full_a;
  logic full_b;
  logic wr_a;
  logic wr_b;

  assign i_ready = !rst && (s ? !full_a : !full_b);
  assign wr_a    = i_valid && i_ready && s;
  assign wr_b    = i_valid && i_ready && !s;

  demux1to2_chan #(.N(N), .CW(CW)) u_chan_a (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr_a),
    .din     (i_data),
    .o_valid (a_valid),
    .o_ready (a_ready),
    .o_data  (a_data),
    .o_full  (full_a),
    .o_cnt   (cnt_a)
  );

  demux1to2_chan #(.N(N), .CW(CW)) u_chan_b (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr_b),
    .din     (i_data),
    .o_valid (b_valid),
    .o_ready (b_ready),
    .o_data  (b_data),
    .o_full  (full_b),
    .o_cnt   (cnt_b)
  );
endmodule

// File: tb/tb_demux1to2_stream_wn.sv
// Directed and randomized checks for demux1to2_stream_wn; a second instance with CW=2 covers counter wrap.

module tb_demux1to2_stream_wn;
  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [3:0]  i_data;
  logic        s;
  logic        i_ready;
  logic        a_valid, b_valid;
  logic [3:0]  a_data, b_data;
  logic        a_ready, b_ready;
  logic [15:0] cnt_a, cnt_b;
  logic        i_ready2, a_valid2, b_valid2;
  logic [3:0]  a_data2, b_data2;
  logic [1:0]  cnt_a2, cnt_b2;

  int checks = 0;
  int errors = 0;

  demux1to2_stream_wn #(.N(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .s(s),
    .i_ready(i_ready), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  demux1to2_stream_wn #(.N(4), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .s(s),
    .i_ready(i_ready2), .a_valid(a_valid2), .a_data(a_data2), .a_ready(a_ready),
    .b_valid(b_valid2), .b_data(b_data2), .b_ready(b_ready),
    .cnt_a(cnt_a2), .cnt_b(cnt_b2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  qa[$];
  logic [3:0]  qb[$];
  logic [15:0] mcnt_a, mcnt_b;
  logic [1:0]  exp_wrap[5];
  logic        m_rdy, m_wa, m_wb, m_ra, m_rb;

  initial begin
    exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b1; i_valid = 1'b1; s = 1'b1; i_data = 4'h5; a_ready = 1'b1; b_ready = 1'b1;

    // Reset: upstream word offered during reset must not be taken
    #1;
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    cyc(); cyc();
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    i_valid = 1'b0; rst = 1'b0;
    cyc();
    chk("post_rst_a_valid", 32'(a_valid), 32'd0);

    // Single word to channel a
    i_valid = 1'b1; s = 1'b1; i_data = 4'h3;
    #1 chk("w3_i_ready", 32'(i_ready), 32'd1);
    cyc();
    i_valid = 1'b0;
    chk("w3_a_valid", 32'(a_valid), 32'd1);
    chk("w3_a_data", 32'(a_data), 32'h3);
    chk("w3_b_valid", 32'(b_valid), 32'd0);
    cyc();
    chk("w3_cnt_a", 32'(cnt_a), 32'd1);
    chk("w3_a_drained", 32'(a_valid), 32'd0);

    // Channel b stalled; channel a keeps accepting
    b_ready = 1'b0; s = 1'b0; i_valid = 1'b1; i_data = 4'h1;
    #1 chk("b1_i_ready", 32'(i_ready), 32'd1);
    cyc();
    i_data = 4'h2;
    #1 chk("b2_i_ready", 32'(i_ready), 32'd1);
    cyc();
    i_data = 4'h3;
    #1 chk("b3_i_ready_full", 32'(i_ready), 32'd0);
    cyc();
    chk("b_full_head", 32'(b_data), 32'h1);
    s = 1'b1; i_data = 4'h7;
    #1 chk("a7_i_ready", 32'(i_ready), 32'd1);
    cyc();
    chk("a7_a_valid", 32'(a_valid), 32'd1);
    chk("a7_a_data", 32'(a_data), 32'h7);
    chk("b_stall_data", 32'(b_data), 32'h1);
    s = 1'b0; i_data = 4'h3;
    #1 chk("b3_still_blocked", 32'(i_ready), 32'd0);
    cyc();
    chk("a7_cnt_a", 32'(cnt_a), 32'd2);
    b_ready = 1'b1;
    #1 chk("b_release_i_ready", 32'(i_ready), 32'd0);
    cyc();
    chk("b_after1_data", 32'(b_data), 32'h2);
    chk("b_after1_cnt", 32'(cnt_b), 32'd1);
    #1 chk("b3_accept_i_ready", 32'(i_ready), 32'd1);
    cyc();
    i_valid = 1'b0;
    chk("b3_head", 32'(b_data), 32'h3);
    chk("b3_valid", 32'(b_valid), 32'd1);
    chk("b3_cnt", 32'(cnt_b), 32'd2);
    cyc();
    chk("b_drain_cnt", 32'(cnt_b), 32'd3);
    chk("b_drain_valid", 32'(b_valid), 32'd0);

    // Alternating stream at full rate
    for (int k = 0; k < 16; k++) begin
      i_valid = 1'b1; s = (k % 2 == 0); i_data = 4'(k);
      #1 chk("alt_i_ready", 32'(i_ready), 32'd1);
      cyc();
      if (k % 2 == 0) begin
        chk("alt_a_data", 32'(a_data), 32'(k));
        chk("alt_a_valid", 32'(a_valid), 32'd1);
        chk("alt_b_idle", 32'(b_valid), 32'd0);
      end else begin
        chk("alt_b_data", 32'(b_data), 32'(k));
        chk("alt_b_valid", 32'(b_valid), 32'd1);
        chk("alt_a_idle", 32'(a_valid), 32'd0);
      end
    end
    i_valid = 1'b0;
    cyc();
    chk("alt_cnt_a", 32'(cnt_a), 32'd10);
    chk("alt_cnt_b", 32'(cnt_b), 32'd11);

    // Counter wrap on the CW=2 instance
    rst = 1'b1; cyc(); rst = 1'b0;
    s = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_valid = (k < 5); i_data = 4'(k + 8);
      cyc();
      if (k >= 1) chk("wrap_cnt_a2", 32'(cnt_a2), 32'(exp_wrap[k-1]));
    end
    i_valid = 1'b0;
    chk("wrap_cnt_a16", 32'(cnt_a), 32'd5);

    // Reset while channel a is full
    a_ready = 1'b0; i_valid = 1'b1; s = 1'b1; i_data = 4'h5;
    cyc();
    i_data = 4'h6;
    cyc();
    #1 chk("fill_i_ready", 32'(i_ready), 32'd0);
    i_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_a_valid", 32'(a_valid), 32'd0);
    chk("midrst_cnt_a", 32'(cnt_a), 32'd0);
    i_valid = 1'b1; i_data = 4'h9;
    cyc();
    i_valid = 1'b0;
    chk("midrst_a_data", 32'(a_data), 32'h9);
    chk("midrst_a_valid1", 32'(a_valid), 32'd1);
    a_ready = 1'b1;
    cyc();
    chk("midrst_cnt_a1", 32'(cnt_a), 32'd1);
    chk("midrst_a_empty", 32'(a_valid), 32'd0);

    // Randomized traffic against a queue model
    rst = 1'b1; cyc(); rst = 1'b0;
    qa.delete(); qb.delete(); mcnt_a = '0; mcnt_b = '0;
    for (int c = 0; c < 10000; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      s       = 1'($urandom_range(0, 1));
      i_data  = 4'($urandom_range(0, 15));
      a_ready = ($urandom_range(0, 3) != 0);
      b_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_rdy = s ? (qa.size() < 2) : (qb.size() < 2);
      chk("rnd_i_ready", 32'(i_ready), 32'(m_rdy));
      chk("rnd_a_valid", 32'(a_valid), 32'(qa.size() != 0));
      chk("rnd_b_valid", 32'(b_valid), 32'(qb.size() != 0));
      if (qa.size() != 0) chk("rnd_a_data", 32'(a_data), 32'(qa[0]));
      if (qb.size() != 0) chk("rnd_b_data", 32'(b_data), 32'(qb[0]));
      chk("rnd_cnt_a", 32'(cnt_a), 32'(mcnt_a));
      chk("rnd_cnt_b", 32'(cnt_b), 32'(mcnt_b));
      m_wa = i_valid && m_rdy && s;
      m_wb = i_valid && m_rdy && !s;
      m_ra = (qa.size() != 0) && a_ready;
      m_rb = (qb.size() != 0) && b_ready;
      cyc();
      if (m_ra) begin void'(qa.pop_front()); mcnt_a = mcnt_a + 16'd1; end
      if (m_rb) begin void'(qb.pop_front()); mcnt_b = mcnt_b + 16'd1; end
      if (m_wa) qa.push_back(i_data);
      if (m_wb) qb.push_back(i_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
